// File: rtl/inst_sequencer.sv
// ---------------------------------------------------------------------------
// inst_sequencer
//
// Small instruction sequencer. It holds a loadable instruction memory and
// issues one instruction at a time to a datapath. It supports single-step
// (edge-detected button), free-run and branch redirection. Completion of
// each instruction is signalled by the datapath through exec_done.
//
// Ports
//   clk           : single clock, rising edge
//   reset         : asynchronous active-high reset
//   load_we       : one-cycle strobe, writes ext_inst to mem[inst_count]
//   ext_inst      : instruction word to load (IW bits)
//   clear         : synchronous program clear (count, pc, state)
//   step          : raw single-step button level
//   run           : free-run enable (level)
//   exec_done     : datapath finished the issued instruction
//   branch_taken  : sampled with exec_done, selects branch_target
//   branch_target : next pc when branch_taken is high
//   inst_out      : registered instruction being issued
//   exec_valid    : inst_out valid, waiting for exec_done
//   pc            : current program counter
//   inst_count    : number of loaded instructions (0..DEPTH)
//   halted        : high while in HALT
//   full          : high when inst_count == DEPTH
// ---------------------------------------------------------------------------
module inst_sequencer #(
   parameter  int DEPTH = 16,
   parameter  int IW    = 12,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_we,
   input  logic [IW-1:0] ext_inst,
   input  logic          clear,
   input  logic          step,
   input  logic          run,
   input  logic          exec_done,
   input  logic          branch_taken,
   input  logic [AW-1:0] branch_target,
   output logic [IW-1:0] inst_out,
   output logic          exec_valid,
   output logic [AW-1:0] pc,
   output logic [CW-1:0] inst_count,
   output logic          halted,
   output logic          full
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [CW-1:0] COUNT_ONE_C  = CW'(1);
   localparam logic [CW-1:0] COUNT_ZERO_C = CW'(0);
   localparam logic [CW-1:0] COUNT_FULL_C = CW'(DEPTH);

   // Instruction storage; deliberately not touched by reset or clear.
   logic [IW-1:0] mem_r [DEPTH];

   state_t        state_r;
   state_t        state_nx_s;
   logic [AW-1:0] pc_r;
   logic [AW-1:0] pc_nx_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nx_s;
   logic [IW-1:0] inst_out_r;
   logic [IW-1:0] inst_out_nx_s;
   logic          exec_valid_r;
   logic          exec_valid_nx_s;
   logic          halted_r;
   logic          halted_nx_s;
   logic          full_r;
   logic          full_nx_s;
   logic          step_q_r;

   logic          step_pulse_s;
   logic          load_ok_s;
   logic          mem_we_s;
   logic [CW-1:0] pc_ext_s;
   logic [CW-1:0] next_pc_s;

   assign step_pulse_s = step & ~step_q_r;
   assign load_ok_s    = load_we & ~full_r;
   assign pc_ext_s     = {1'b0, pc_r};

   // Next pc is formed one bit wider than pc so that running off the end of
   // the program (or branching past it) is seen as >= inst_count, not wrapped.
   assign next_pc_s = branch_taken ? {1'b0, branch_target} : (pc_ext_s + COUNT_ONE_C);

   // Next-state, next-pc, count and instruction register selection.
   always_comb begin
      state_nx_s    = state_r;
      pc_nx_s       = pc_r;
      count_nx_s    = count_r;
      inst_out_nx_s = inst_out_r;
      mem_we_s      = 1'b0;

      if (clear) begin
         // Clear aborts anything in flight and outranks a coincident load.
         state_nx_s = S_IDLE;
         pc_nx_s    = {AW{1'b0}};
         count_nx_s = COUNT_ZERO_C;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (load_ok_s) begin
                  // A load beats a coincident start request.
                  mem_we_s   = 1'b1;
                  count_nx_s = count_r + COUNT_ONE_C;
                  pc_nx_s    = {AW{1'b0}};
                  state_nx_s = S_IDLE;
               end else if (run | step_pulse_s) begin
                  if (pc_ext_s < count_r) begin
                     state_nx_s = S_FETCH;
                  end else if (count_r != COUNT_ZERO_C) begin
                     state_nx_s = S_HALT;
                  end else begin
                     state_nx_s = S_IDLE;
                  end
               end else begin
                  state_nx_s = S_IDLE;
               end
            end

            S_FETCH: begin
               inst_out_nx_s = mem_r[pc_r];
               state_nx_s    = S_EXEC;
            end

            S_EXEC: begin
               if (exec_done) begin
                  pc_nx_s = next_pc_s[AW-1:0];
                  if (next_pc_s >= count_r) begin
                     state_nx_s = S_HALT;
                  end else if (run) begin
                     state_nx_s = S_FETCH;
                  end else begin
                     state_nx_s = S_IDLE;
                  end
               end else begin
                  state_nx_s = S_EXEC;
               end
            end

            S_HALT: begin
               // Only a load (or clear/reset) leaves HALT; step and run are ignored.
               if (load_ok_s) begin
                  mem_we_s   = 1'b1;
                  count_nx_s = count_r + COUNT_ONE_C;
                  pc_nx_s    = {AW{1'b0}};
                  state_nx_s = S_IDLE;
               end else begin
                  state_nx_s = S_HALT;
               end
            end

            default: begin
               state_nx_s = S_IDLE;
            end
         endcase
      end
   end

   // Status flags are registered from the next-state view so they line up
   // with the state and count registers.
   always_comb begin
      exec_valid_nx_s = (state_nx_s == S_EXEC);
      halted_nx_s     = (state_nx_s == S_HALT);
      full_nx_s       = (count_nx_s == COUNT_FULL_C);
   end

   // State, datapath and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= S_IDLE;
         pc_r         <= {AW{1'b0}};
         count_r      <= COUNT_ZERO_C;
         inst_out_r   <= {IW{1'b0}};
         exec_valid_r <= 1'b0;
         halted_r     <= 1'b0;
         full_r       <= 1'b0;
         step_q_r     <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         pc_r         <= pc_nx_s;
         count_r      <= count_nx_s;
         inst_out_r   <= inst_out_nx_s;
         exec_valid_r <= exec_valid_nx_s;
         halted_r     <= halted_nx_s;
         full_r       <= full_nx_s;
         step_q_r     <= step;
      end
   end

   // Instruction memory write port; the write address is the current count.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[count_r[AW-1:0]] <= ext_inst;
      end
   end

   assign inst_out   = inst_out_r;
   assign exec_valid = exec_valid_r;
   assign pc         = pc_r;
   assign inst_count = count_r;
   assign halted     = halted_r;
   assign full       = full_r;

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 16, giving the instruction memory entry count; the width of pc and target fields is log2(DEPTH).
REQ-002 The block SHALL have the parameter IW, default 12, giving the instruction width.
REQ-003 Port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port load_we, input, 1: a single-cycle write strobe that writes ext_inst to mem[inst_count].
REQ-006 Port ext_inst, input, IW: the instruction word to load.
REQ-007 Port clear, input, 1: program clear, synchronous.
REQ-008 Port step, input, 1: raw level from the single-step button.
REQ-009 Port run, input, 1: free-run enable, level sensitive.
REQ-010 Port exec_done, input, 1: the datapath has completed the issued instruction.
REQ-011 Port branch_taken, input, 1: sampled with exec_done; selects branch_target as the next pc.
REQ-012 Port branch_target, input, 4: the next pc when branch_taken is high.
REQ-013 Port inst_out, output, IW: the registered instruction being issued.
REQ-014 Port exec_valid, output, 1: inst_out is valid and awaiting exec_done.
REQ-015 Port pc, output, 4: the current program counter.
REQ-016 Port inst_count, output, 5: the number of loaded instructions, from 0 to DEPTH.
REQ-017 Port halted, output, 1: high in the HALT state.
REQ-018 Port full, output, 1: high when inst_count==DEPTH.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT, with exactly one state active.
REQ-020 The step input SHALL be edge-detected internally: step_pulse = step & ~step_q, and step_q SHALL be registered.
REQ-021 In IDLE or HALT, load_we with full low SHALL write mem[inst_count], increment inst_count, and set pc to 0; a HALT state SHALL then move to IDLE.
REQ-022 load_we while full is high, or in FETCH or EXEC, SHALL be ignored, with no write and no count change.
REQ-023 In IDLE, (run or step_pulse) with pc<inst_count SHALL move the FSM to FETCH; with pc>=inst_count and inst_count>0 the FSM SHALL move to HALT; with inst_count==0 it SHALL stay in IDLE.
REQ-024 If load_we and a start condition coincide in IDLE, the load SHALL win and the FSM SHALL stay in IDLE.
REQ-025 FETCH SHALL last one cycle: inst_out <= mem[pc], then the FSM SHALL move to EXEC.
REQ-026 In EXEC, exec_valid SHALL be 1 and inst_out SHALL be held stable until the cycle in which exec_done is 1, which completes the instruction; exec_done SHALL be ignored outside EXEC.
REQ-027 On completion, the next pc SHALL be branch_taken ? branch_target : pc+1, computed 5 bits wide with no wrap.
REQ-028 After completion: if the next pc >= inst_count the FSM SHALL move to HALT; else if run==1 it SHALL move to FETCH; else it SHALL move to IDLE.
REQ-029 Step mode SHALL execute exactly one instruction per step_pulse.
REQ-030 exec_valid SHALL deassert in the cycle after completion.
REQ-031 A step_pulse outside IDLE SHALL be discarded and not queued.
REQ-032 Run deasserting mid-EXEC SHALL let the current instruction finish, after which the FSM SHALL go to IDLE.
REQ-033 In HALT, step and run SHALL be ignored; the FSM SHALL leave HALT only on load_we, clear or reset.
REQ-034 clear in any state SHALL set inst_count=0, pc=0 and state IDLE, and SHALL drop exec_valid next cycle, aborting an in-flight EXEC without waiting for exec_done; clear SHALL have priority over load_we.
REQ-035 Memory contents SHALL be left unchanged by clear and by reset.
REQ-036 Minimum instruction latency SHALL be 3 cycles from IDLE start to the next IDLE or FETCH when exec_done arrives in the first EXEC cycle.

Reset
REQ-037 On reset assertion, asynchronously: state=IDLE, pc=0, inst_count=0, inst_out=0, exec_valid=0, halted=0, full=0, step_q=0.
REQ-038 After reset deassertion, the block SHALL respond to inputs from the first following rising edge.

Verification
REQ-039 Load 8 words (0x200,0x211,0x020,0x6C8,0x51A,0x943,0xA4E,0xC07) -> inst_count=8, pc=0, full=0, state IDLE.
REQ-040 Hold step high for 5 cycles with exec_done tied to 1 -> exactly one issue (inst_out=0x200, exec_valid 1 cycle), pc=1, IDLE.
REQ-041 With 8 words loaded, hold run=1 with exec_done delayed 2 cycles each -> 8 issues in order, exec_valid held during waits, pc=8, halted=1; then step -> no change.
REQ-042 Branch: at pc=3, branch_taken=1 and branch_target=1 -> the next fetch reads mem[1]; branch_target=9 with inst_count=8 -> HALT.
REQ-043 Perform 17 load_we pulses -> inst_count=16, full=1, and the 17th word is not written.
REQ-044 Assert clear in EXEC without exec_done -> next cycle exec_valid=0, inst_count=0, pc=0, IDLE; assert reset mid-run -> all outputs at reset values immediately.
